coffee_controller: RTL and testbench

Coffee-machine sequencer for the FPGA board top level. It divides the board clock into a slow step tick, lets the user choose a drink (Expreso, Latte or Capuchino) with a "next" button and start it with a "select" button, then steps through the preparation stages. The drink and the current stage are shown on two 7-segment digits, and the stage is also shown on five LEDs.

---
 rtl/coffee_pkg.sv | 62 ++++++
 rtl/coffee_tick_gen.sv | 28 ++
 rtl/coffee_controller.sv | 113 +++++++++++
 tb/tb_coffee_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared types and decode helpers for the coffee-machine sequencer.
package coffee_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRIND = 3'd1,
        HEAT  = 3'd2,
        BREW  = 3'd3,
        MILK  = 3'd4,
        FOAM  = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        EXPRESO   = 2'd0,
        LATTE     = 2'd1,
        CAPUCHINO = 2'd2
    } drink_t;

    localparam logic [4:0] LED_DONE = 5'b11111;

    // Active-low {g,f,e,d,c,b,a}; codes without a glyph blank the digit.
    function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    function automatic drink_t next_drink(input drink_t cur);
        drink_t nxt;
        case (cur)
            EXPRESO: nxt = LATTE;
            LATTE:   nxt = CAPUCHINO;
            default: nxt = EXPRESO;
        endcase
        return nxt;
    endfunction

    // Milk stages are skipped by drinks that do not use them.
    function automatic state_t next_stage(input state_t cur, input drink_t drink);
        state_t nxt;
        case (cur)
            GRIND:   nxt = HEAT;
            HEAT:    nxt = BREW;
            BREW:    nxt = (drink == EXPRESO) ? DONE : MILK;
            MILK:    nxt = (drink == LATTE) ? DONE : FOAM;
            FOAM:    nxt = DONE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/coffee_tick_gen.sv
// Divides the board clock into a single-cycle step tick every TICK_DIV clocks.
module coffee_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic slow_clk
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;

    // Free-running divider counter wrapping at TICK_DIV-1
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == CNT_LAST) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    assign slow_clk = (div_cnt_r == CNT_LAST);

endmodule

// File: rtl/coffee_controller.sv
// Coffee-machine sequencer: drink selection, stage stepping and display decode.
// Define COFFEE_FAST_TICK_EN to force a divide-by-16 step tick for simulation.
module coffee_controller #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int STEP_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_button,
    input  logic       select_button,
    output logic [6:0] seg_type,
    output logic [6:0] seg_state,
    output logic [4:0] led
);

    import coffee_pkg::*;

`ifdef COFFEE_FAST_TICK_EN
    localparam int EFF_DIV = 16;
`else
    localparam int EFF_DIV = TICK_DIV;
`endif

    localparam int DWELL_W = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(STEP_TICKS - 1);

    logic               slow_clk;
    state_t             state;
    drink_t             drink_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               next_pend_r;
    logic               sel_pend_r;
    logic               next_prev_r;
    logic               sel_prev_r;
    logic               next_rise_s;
    logic               sel_rise_s;

    coffee_tick_gen #(
        .TICK_DIV (EFF_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .slow_clk (slow_clk)
    );

    assign next_rise_s = next_button & ~next_prev_r;
    assign sel_rise_s  = select_button & ~sel_prev_r;

    // Sequencer FSM with button capture; everything moves only on the step tick except capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            drink_r     <= EXPRESO;
            dwell_r     <= '0;
            next_pend_r <= 1'b0;
            sel_pend_r  <= 1'b0;
            next_prev_r <= 1'b0;
            sel_prev_r  <= 1'b0;
        end else begin
            next_prev_r <= next_button;
            sel_prev_r  <= select_button;
            if (state == IDLE) begin
                if (slow_clk) begin
                    if (sel_pend_r) begin
                        state       <= GRIND;
                        dwell_r     <= '0;
                        sel_pend_r  <= 1'b0;
                        next_pend_r <= 1'b0;
                    end else begin
                        if (next_pend_r) begin
                            drink_r <= next_drink(drink_r);
                        end
                        // A press coinciding with this tick survives for the next one.
                        sel_pend_r  <= sel_rise_s;
                        next_pend_r <= next_rise_s;
                    end
                end else begin
                    sel_pend_r  <= sel_pend_r | sel_rise_s;
                    next_pend_r <= next_pend_r | next_rise_s;
                end
            end else begin
                sel_pend_r  <= 1'b0;
                next_pend_r <= 1'b0;
                if (slow_clk) begin
                    if (dwell_r == DWELL_LAST) begin
                        state   <= next_stage(state, drink_r);
                        dwell_r <= '0;
                    end else begin
                        dwell_r <= dwell_r + DWELL_W'(1);
                    end
                end
            end
        end
    end

    // Display and LED decode straight from the state and drink registers
    always_comb begin
        led = 5'b00000;
        case (state)
            IDLE:    led = 5'b00000;
            GRIND:   led = 5'b00001;
            HEAT:    led = 5'b00010;
            BREW:    led = 5'b00100;
            MILK:    led = 5'b01000;
            FOAM:    led = 5'b10000;
            DONE:    led = LED_DONE;
            default: led = 5'b00000;
        endcase
        seg_type  = seg7_digit({2'b00, drink_r} + 4'd1);
        seg_state = seg7_digit({1'b0, state});
    end

endmodule

// File: tb/tb_coffee_controller.sv
// Scoreboard bench for coffee_controller: expected stage/drink per tick is queued at stimulus time.
module tb_coffee_controller;

    localparam int STEP = 2;

    typedef struct {
        int st;
        int dr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       next_button;
    logic       select_button;
    logic [6:0] seg_type;
    logic [6:0] seg_state;
    logic [4:0] led;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    coffee_controller #(
        .TICK_DIV   (8),
        .STEP_TICKS (STEP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .next_button   (next_button),
        .select_button (select_button),
        .seg_type      (seg_type),
        .seg_state     (seg_state),
        .led           (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int exp_led(input int st);
        case (st)
            1:       return 5'b00001;
            2:       return 5'b00010;
            3:       return 5'b00100;
            4:       return 5'b01000;
            5:       return 5'b10000;
            6:       return 5'b11111;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int st, input int dr);
        exp_t e;
        e.st = st;
        e.dr = dr;
        sb.push_back(e);
    endtask

    task automatic push_stage(input int st, input int dr);
        for (int k = 0; k < STEP; k++) push(st, dr);
    endtask

    // Full preparation of one drink followed by the return to IDLE.
    task automatic push_drink(input int dr);
        push_stage(1, dr);
        push_stage(2, dr);
        push_stage(3, dr);
        if (dr >= 1) push_stage(4, dr);
        if (dr == 2) push_stage(5, dr);
        push_stage(6, dr);
        push(0, dr);
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_state"}, int'(dut.state), e.st);
            check({tag, "_led"}, int'(led), exp_led(e.st));
            check({tag, "_seg_type"}, int'(seg_type), exp_seg(e.dr + 1));
            check({tag, "_seg_state"}, int'(seg_state), exp_seg(e.st));
        end
    endtask

    // Called at a negedge; returns at the negedge just after the next tick edge.
    task automatic wait_tick();
        int n;
        n = 0;
        while (dut.slow_clk !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("tick_wait", int'(dut.slow_clk), 1);
        @(negedge clk);
    endtask

    task automatic drain(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            wait_tick();
            compare_front(tag);
        end
    endtask

    task automatic press(input bit nxt, input bit sel, input int cyc);
        next_button   = nxt;
        select_button = sel;
        repeat (cyc) @(negedge clk);
        next_button   = 1'b0;
        select_button = 1'b0;
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        next_button   = 1'b0;
        select_button = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", int'(dut.state), 0);
        check("rst_led", int'(led), 0);
        check("rst_seg_type", int'(seg_type), 7'b1111001);
        check("rst_seg_state", int'(seg_state), 7'b1000000);
        check("rst_slow_clk", int'(dut.slow_clk), 0);
        reset = 1'b0;

        push(0, 0);
        drain(1, "idle");

        // Expreso: short select pulse
        press(1'b0, 1'b1, 2);
        push_drink(0);
        drain(9, "expreso");

        // Latte
        press(1'b1, 1'b0, 2);
        push(0, 1);
        drain(1, "next_latte");
        press(1'b0, 1'b1, 2);
        push_drink(1);
        drain(11, "latte");

        // Capuchino with a single-cycle next pulse
        press(1'b1, 1'b0, 1);
        push(0, 2);
        drain(1, "next_capu");
        press(1'b0, 1'b1, 1);
        push_drink(2);
        drain(13, "capuchino");

        // Wrap back to Expreso
        press(1'b1, 1'b0, 2);
        push(0, 0);
        drain(1, "wrap");

        // Both pending on one tick: select wins; presses during BREW are dropped
        press(1'b1, 1'b1, 2);
        push_drink(0);
        push(0, 0);
        push(0, 0);
        drain(5, "combo");
        press(1'b0, 1'b1, 2);
        press(1'b1, 1'b0, 2);
        drain(6, "combo_tail");

        // Three nexts on separate ticks: digits 2, 3, 1
        for (int i = 1; i <= 3; i++) begin
            press(1'b1, 1'b0, 2);
            push(0, i % 3);
            drain(1, "next_seq");
        end

        // Press landing in the tick cycle acts on the following tick
        n = 0;
        while (dut.slow_clk !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("align_tick", int'(dut.slow_clk), 1);
        next_button = 1'b1;
        @(negedge clk);
        next_button = 1'b0;
        push(0, 0);
        compare_front("tick_press_now");
        push(0, 1);
        drain(1, "tick_press_next");

        // Reset in BREW aborts the Latte; a select pressed in BREW does not restart it
        press(1'b0, 1'b1, 2);
        push_stage(1, 1);
        push_stage(2, 1);
        push(3, 1);
        drain(5, "pre_abort");
        press(1'b0, 1'b1, 2);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", int'(dut.state), 0);
        check("abort_led", int'(led), 0);
        check("abort_seg_type", int'(seg_type), 7'b1111001);
        check("abort_seg_state", int'(seg_state), 7'b1000000);
        reset = 1'b0;
        push(0, 0);
        push(0, 0);
        push(0, 0);
        drain(3, "post_abort");

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
